// File: rtl/seg_scan_pkg.sv
// Shared widths, scan state encoding and the leading-zero helper for the
// seven-segment scan controller.
package seg_scan_pkg;

  localparam int DIGITS = 8;
  localparam int SEL_W  = 3;
  localparam int NIB_W  = 4;
  localparam int DATA_W = 32;

  typedef enum logic {BLANK, SCAN} scan_state_t;

  // True when digit k (k >= 1) and every digit above it are zero.
  function automatic logic lead_zero(input logic [DATA_W-1:0] d,
                                     input logic [SEL_W-1:0]  k);
    logic nz;
    nz = 1'b0;
    for (int j = 0; j < DIGITS; j++) begin
      if (j >= int'(k) && d[NIB_W*j +: NIB_W] != '0) nz = 1'b1;
    end
    return (k != '0) && !nz;
  endfunction

endpackage

// File: rtl/seg_prescaler.sv
// Digit-hold prescaler: counts 0..DIV-1 and flags the last count as tick.
module seg_prescaler #(
  parameter int DIV = 100000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int                CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0]  TC    = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = ~i_clr & (r_cnt == TC);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || r_cnt == TC) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit hex scan controller with frame-synchronous double buffering.
// Optional LEADING_ZERO_BLANK_EN also blanks leading zero digits above digit 0.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int DIV = 100000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic              i_load,
  input  logic [DIGITS-1:0] i_digit_mask,
  output logic [NIB_W-1:0]  o_num,
  output logic [SEL_W-1:0]  o_sel,
  output logic              o_blank,
  output logic              o_commit
);

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(DIGITS - 1);

  scan_state_t        r_state;
  logic [SEL_W-1:0]   r_sel;
  logic [NIB_W-1:0]   r_num;
  logic               r_blank;
  logic               r_commit;
  logic [DATA_W-1:0]  r_display;
  logic [DATA_W-1:0]  r_shadow;
  logic               r_pending;

  logic               w_clr;
  logic               w_tick;
  logic               w_commit;
  logic [DATA_W-1:0]  w_disp_nxt;
  logic [SEL_W-1:0]   w_sel_nxt;
  logic               w_blank_nxt;

  assign w_clr = (r_state == BLANK) | ~i_en;

  seg_prescaler #(.DIV(DIV)) u_prescaler (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_clr),
    .o_tick  (w_tick)
  );

  // A load landing on the frame boundary bypasses the shadow entirely.
  assign w_commit   = w_tick & (r_sel == SEL_LAST) & (i_load | r_pending);
  assign w_disp_nxt = !w_commit ? r_display : (i_load ? i_data_in : r_shadow);
  assign w_sel_nxt  = (r_state == SCAN) ? r_sel + SEL_W'(1) : '0;

`ifdef LEADING_ZERO_BLANK_EN
  assign w_blank_nxt = ~i_digit_mask[w_sel_nxt] | lead_zero(w_disp_nxt, w_sel_nxt);
`else
  assign w_blank_nxt = ~i_digit_mask[w_sel_nxt];
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= BLANK;
      r_sel     <= '0;
      r_num     <= '0;
      r_blank   <= 1'b1;
      r_commit  <= 1'b0;
      r_display <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
    end else begin
      r_commit  <= w_commit;
      r_display <= w_disp_nxt;
      if (i_load) r_shadow <= i_data_in;
      if (w_commit)    r_pending <= 1'b0;
      else if (i_load) r_pending <= 1'b1;

      case (r_state)
        BLANK: begin
          if (i_en) begin
            r_state <= SCAN;
            r_sel   <= w_sel_nxt;
            r_num   <= w_disp_nxt[NIB_W*w_sel_nxt +: NIB_W];
            r_blank <= w_blank_nxt;
          end else begin
            r_sel   <= '0;
            r_num   <= '0;
            r_blank <= 1'b1;
          end
        end
        SCAN: begin
          if (!i_en) begin
            r_state <= BLANK;
            r_sel   <= '0;
            r_num   <= '0;
            r_blank <= 1'b1;
          end else if (w_tick) begin
            r_sel   <= w_sel_nxt;
            r_num   <= w_disp_nxt[NIB_W*w_sel_nxt +: NIB_W];
            r_blank <= w_blank_nxt;
          end
        end
        default: r_state <= BLANK;
      endcase
    end
  end

  assign o_num    = r_num;
  assign o_sel    = r_sel;
  assign o_blank  = r_blank;
  assign o_commit = r_commit;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller that drives the existing hex-to-seven-segment and digit-select decoder. It holds a 32-bit value (8 hex digits) and cycles the 3-bit digit select. For each digit it presents the matching 4-bit nibble, so the decoder's combinational outputs light one display at a time. New values are double-buffered and committed only at frame boundaries, so a display never shows a mix of old and new digits.

Parameters:
DIV, 100000, clock cycles each digit is held (minimum 2); the refresh rate per digit is f_clk/(DIV*8).
DIGITS, 8, number of scanned digits; fixed at 8 to match the 3-bit select.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  scan enable; low forces blanking
data_in  in  32  value to display; nibble k drives digit k
load  in  1  single-cycle strobe; captures data_in into the shadow register
digit_mask  in  8  per-digit enable, bit k = 1 shows digit k
num  out  4  nibble for the current digit (to decoder num)
sel  out  3  current digit index (to decoder sel)
blank  out  1  high: downstream forces all digit enables inactive
commit  out  1  single-cycle pulse when the shadow value is moved to the display register

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = BLANK; sel = 0; num = 0; blank = 1; commit = 0.
  - Display register, shadow register, pending flag and prescaler all cleared.
- States:
  - BLANK: prescaler held at 0, sel = 0, blank = 1. Moves to SCAN on the first cycle en = 1.
  - SCAN: moves to BLANK on any cycle en = 0. That cycle's registered outputs are sel = 0 and blank = 1.
- Prescaler in SCAN:
  - Counts 0..DIV-1; tick is asserted when the count equals DIV-1, then the count wraps to 0.
  - On tick, sel <= sel + 1, wrapping 7 -> 0.
- Registered outputs:
  - num, sel and blank are registered together, so all three change on the same edge.
  - num = display[4*sel +: 4] for the new sel.
  - blank = ~digit_mask[sel] in SCAN.
  - On entry to SCAN, sel = 0 is presented the cycle after en rises. Each digit is then held exactly DIV cycles.
- Load and commit:
  - load sets the shadow register to data_in and sets pending. A later load before commit overwrites the shadow; the last write wins.
  - A frame boundary is a tick with sel = 7. At a frame boundary with pending = 1: display <= shadow, pending cleared, commit pulses 1 cycle, and digit 0 of the next frame shows the new value.
  - load coincident with a frame boundary: data_in goes directly to display, pending ends cleared, and commit pulses.
  - Loads are accepted in BLANK. The pending value commits at the first frame boundary after SCAN resumes.
- Changes to digit_mask take effect at the next sel update; there is no buffering.
- Deasserting en mid-frame abandons the frame. Re-enabling restarts at digit 0 and the pending flag is kept.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: in SCAN, a digit k is also blanked when every nibble from digit k up to digit 7 of display is zero, for k >= 1. Digit 0 is never blanked by this rule. Example: 0x0000_00A5 shows only digits 1 and 0.
- Not defined: blank depends on digit_mask only.
- With or without the macro, timing and commit behaviour are identical.

Decomposition:
- seg_scan_pkg:
  - localparams: DIGITS = 8, SEL_W = 3, NIB_W = 4, DATA_W = 32.
  - typedef enum logic {BLANK, SCAN} scan_state_t.
- One sub-module, seg_prescaler: DIV-parameterised counter with a clear input and tick output, instantiated once.

Test Plan:
All scenarios run with DIV = 4.
1. Reset, then en = 1, load 0x7654_3210, mask 0xFF. Response:
   - sel steps 0..7, 4 cycles per digit; num equals sel on each digit; blank = 0.
   - commit pulses once at the first frame boundary.
2. Load 0x1111_1111 at sel = 3, then 0x2222_2222 at sel = 5. Response:
   - Digits 3..7 still show the old nibbles.
   - At the frame boundary commit pulses once and every digit then shows 2; 0x1111_1111 is never displayed.
3. Load asserted exactly on the sel = 7 tick cycle. Response: the next frame's digit 0 shows the new nibble, commit = 1 that cycle, pending = 0.
4. digit_mask = 0x0F. Response: blank = 1 while sel = 4..7 and blank = 0 while sel = 0..3.
5. en dropped at sel = 5 for 3 cycles, then raised. Response:
   - blank = 1 with sel = 0 during the gap.
   - Restarts at sel = 0, held a full 4 cycles.
6. rst_n pulsed low mid-frame (asynchronous, between edges). Response:
   - Outputs go immediately to sel = 0, num = 0, blank = 1.
   - After release, nothing is displayed until en and load.
   - With LEADING_ZERO_BLANK_EN: 0x0000_00A5 blanks digits 2..7.
